// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction fetch stage.
package mips_fetch_pkg;

  // TRAP is only reachable when FETCH_MISALIGN_TRAP_EN is defined.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StExec  = 2'd2,
    StTrap  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection: jr > jump > taken branch > sequential.
module fetch_next_pc
  import mips_fetch_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [25:0] instr_index,
  input  logic [31:0] sext_imm,
  input  logic [31:0] jr_addr,
  input  logic        jr,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] next_pc
);

  logic [31:0] branch_target;
  logic [31:0] jump_target;

  // Offset is a word count; the shift drops sext_imm[31:30], which wraps modulo 2^32 anyway.
  assign branch_target = pc_plus4 + {sext_imm[29:0], 2'b00};
  assign jump_target   = {pc_plus4[31:28], instr_index, 2'b00};

  // Priority mux over the redirect sources.
  always_comb begin
    next_pc = pc_plus4;
    if (jr) begin
      next_pc = jr_addr;
    end else if (jump) begin
      next_pc = jump_target;
    end else if (branch && zero) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, imem request FSM and next-PC update.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (trap on misaligned redirect
// target instead of silently clearing next_pc[1:0]).
module instr_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  input  logic [31:0] sext_imm,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  next_pc_raw;
  logic [31:0]  next_pc;
  logic         target_misaligned;

  assign pc_plus4  = pc_q + PC_INCR;
  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign instr     = instr_q;

  fetch_next_pc u_fetch_next_pc (
    .pc_plus4    (pc_plus4),
    .instr_index (instr_q[25:0]),
    .sext_imm    (sext_imm),
    .jr_addr     (jr_addr),
    .jr          (jr),
    .jump        (jump),
    .branch      (branch),
    .zero        (zero),
    .next_pc     (next_pc_raw)
  );

`ifdef FETCH_MISALIGN_TRAP_EN
  assign next_pc           = next_pc_raw;
  assign target_misaligned = |next_pc_raw[1:0];
`else
  logic unused_next_pc_low;
  assign unused_next_pc_low = ^next_pc_raw[1:0];
  assign next_pc            = {next_pc_raw[31:2], 2'b00};
  assign target_misaligned  = 1'b0;
`endif

  // Next-state and output decode; redirects only act on EXEC with stall low.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    misalign    = 1'b0;
    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          instr_d = imem_rdata;
          state_d = StExec;
        end
      end
      StExec: begin
        instr_valid = 1'b1;
        if (!stall) begin
          if (target_misaligned) begin
            state_d = StTrap;
          end else begin
            pc_d    = next_pc;
            state_d = StFetch;
          end
        end
      end
      StTrap: begin
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign = 1'b1;
        state_d  = StTrap;
`else
        state_d  = StIdle;
`endif
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, PC and instruction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed steps plus a random phase,
// all checked against a transaction-level model of the fetch stage.
module tb_instr_fetch_unit;

  localparam logic [31:0] RstPc = 32'h0000_0040;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  // Model phases.
  localparam int MIdle = 0;
  localparam int MWait = 1;
  localparam int MExec = 2;
  localparam int MTrap = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall, branch, zero, jump, jr, imem_valid;
  logic [31:0] jr_addr, sext_imm, imem_rdata;
  logic        imem_req, instr_valid, misalign;
  logic [31:0] imem_addr, instr, pc, pc_plus4;

  int          n_assert = 0;
  int          n_fail = 0;
  int          mode;
  logic [31:0] m_pc, m_instr;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC (RstPc)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .branch      (branch),
    .zero        (zero),
    .jump        (jump),
    .jr          (jr),
    .jr_addr     (jr_addr),
    .sext_imm    (sext_imm),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .misalign    (misalign)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    mode    = MIdle;
    m_pc    = RstPc;
    m_instr = 32'h0;
  endtask

  // One clock edge of the architectural behaviour, using the inputs seen at the edge.
  task automatic model_step();
    logic [31:0] p4, np;
    if (!rst_n) begin
      model_reset();
      return;
    end
    case (mode)
      MIdle: mode = MWait;
      MWait: if (imem_valid) begin
        m_instr = imem_rdata;
        mode    = MExec;
      end
      MExec: if (!stall) begin
        p4 = m_pc + 32'd4;
        if (jr) np = jr_addr;
        else if (jump) np = (p4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
        else if (branch && zero) np = p4 + sext_imm * 4;
        else np = p4;
        if (TrapEn && (np % 4 != 0)) begin
          mode = MTrap;
        end else begin
          m_pc = np - (np % 4);
          mode = MWait;
        end
      end
      default: mode = MTrap;
    endcase
  endtask

  task automatic check_all();
    check("imem_req", {31'b0, imem_req}, {31'b0, mode == MWait});
    check("instr_valid", {31'b0, instr_valid}, {31'b0, mode == MExec});
    check("misalign", {31'b0, misalign}, {31'b0, mode == MTrap});
    check("pc", pc, m_pc);
    check("imem_addr", imem_addr, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("instr", instr, m_instr);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic clear_inputs();
    stall = 0; branch = 0; zero = 0; jump = 0; jr = 0;
    jr_addr = 0; sext_imm = 0; imem_valid = 0; imem_rdata = 0;
  endtask

  // Advance with a ready memory until the model is in EXEC; bounded.
  task automatic to_exec();
    int budget;
    clear_inputs();
    budget = 10;
    while (mode != MExec && budget > 0) begin
      imem_valid = 1;
      imem_rdata = $urandom;
      tick();
      budget--;
    end
    check("to_exec_reached", {31'b0, mode == MExec}, 32'd1);
    clear_inputs();
  endtask

  task automatic jump_reg(input logic [31:0] addr);
    to_exec();
    jr      = 1;
    jr_addr = addr;
    tick();
    clear_inputs();
  endtask

  task automatic pulse_reset();
    #2 rst_n = 0;
    model_reset();
    #1 check_all();
    tick();
    rst_n = 1;
    clear_inputs();
  endtask

  initial begin
    logic [31:0] addr_q[$];
    logic [31:0] saved_pc, saved_instr;

    clear_inputs();
    model_reset();
    #1 rst_n = 0;
    #1 check_all();
    tick();
    rst_n = 1;

    // Zero-wait memory from reset: 0x40, 0x44, 0x48.
    imem_valid = 1;
    repeat (6) begin
      imem_rdata = $urandom;
      tick();
      if (imem_req) addr_q.push_back(imem_addr);
    end
    check("seq_len", addr_q.size(), 32'd3);
    for (int i = 0; i < addr_q.size() && i < 3; i++)
      check("seq_addr", addr_q[i], RstPc + 32'd4 * i);

    // Taken branch backwards from 0x100.
    jump_reg(32'h100);
    to_exec();
    branch = 1; zero = 1; sext_imm = 32'hFFFF_FFFE;
    tick();
    check("branch_taken", imem_addr, 32'h0FC);

    // Branch not taken.
    jump_reg(32'h100);
    to_exec();
    branch = 1; zero = 0; sext_imm = 32'hFFFF_FFFE;
    tick();
    check("branch_not_taken", imem_addr, 32'h104);

    // All redirects at once: jr wins.
    to_exec();
    jr = 1; jump = 1; branch = 1; zero = 1; jr_addr = 32'h2000; sext_imm = 32'h10;
    tick();
    check("priority_jr", imem_addr, 32'h2000);

    // Stall for 3 cycles with redirects asserted, then a 2-cycle memory wait.
    to_exec();
    saved_pc    = pc;
    saved_instr = instr;
    stall = 1; jr = 1; jr_addr = 32'h3000;
    repeat (3) begin
      tick();
      check("stall_pc", pc, saved_pc);
      check("stall_instr", instr, saved_instr);
    end
    clear_inputs();
    tick();
    check("post_stall_pc", pc, saved_pc + 32'd4);
    repeat (2) begin
      tick();
      check("wait_no_valid", {31'b0, instr_valid}, 32'd0);
    end
    imem_valid = 1;
    imem_rdata = 32'hA5A5_1234;
    tick();
    check("valid_after_wait", {31'b0, instr_valid}, 32'd1);
    check("instr_after_wait", instr, 32'hA5A5_1234);
    clear_inputs();

    // Sequential wrap at the top of the address space.
    jump_reg(32'hFFFF_FFFC);
    to_exec();
    tick();
    check("pc_wrap", pc, 32'h0000_0000);

    // Reset while fetching with valid data on the bus.
    imem_valid = 1;
    imem_rdata = 32'hDEAD_BEEF;
    pulse_reset();
    check("rst_instr", instr, 32'h0);
    check("rst_pc", pc, RstPc);

    // Misaligned jr target.
    to_exec();
    jr = 1; jr_addr = 32'h1002;
    tick();
    clear_inputs();
    if (TrapEn) begin
      repeat (3) begin
        imem_valid = 1;
        tick();
        check("trap_misalign", {31'b0, misalign}, 32'd1);
        check("trap_no_req", {31'b0, imem_req}, 32'd0);
      end
      pulse_reset();
    end else begin
      check("aligned_jr", pc, 32'h1000);
    end

    // Random phase against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 0;
        model_reset();
      end else begin
        rst_n = 1;
      end
      stall      = ($urandom_range(0, 3) == 0);
      jr         = ($urandom_range(0, 7) == 0);
      jr_addr    = $urandom & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      jump       = ($urandom_range(0, 5) == 0);
      branch     = ($urandom_range(0, 2) == 0);
      zero       = $urandom_range(0, 1);
      sext_imm   = $urandom;
      imem_valid = ($urandom_range(0, 2) != 0);
      imem_rdata = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the MIPS datapath. Holds the program counter, requests instructions from instruction memory, and presents the fetched word whose bits [15:0] drive the 16-to-32-bit immediate sign extender. Computes the next PC from sequential, branch, jump and jump-register redirects. The branch offset comes back from the sign extender's 32-bit output.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold current instruction; no PC update.
- branch  in  1  current instruction is a conditional branch.
- zero  in  1  ALU zero flag; branch taken when branch && zero.
- jump  in  1  J-type jump.
- jr  in  1  jump register.
- jr_addr  in  32  register target for jr.
- sext_imm  in  32  sign-extended immediate of the current instruction.
- imem_req  out  1  instruction memory read request.
- imem_addr  out  32  read address, equal to pc.
- imem_rdata  in  32  read data.
- imem_valid  in  1  imem_rdata valid this cycle.
- instr  out  32  current instruction; bits [15:0] feed the sign extender.
- instr_valid  out  1  instr is valid and executing.
- pc  out  32  address of the current instruction.
- pc_plus4  out  32  pc + 4.
- misalign  out  1  misaligned target trap; present only with the macro.

## Operation
- Clock and reset are fixed: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- FSM states: IDLE, FETCH, EXEC, plus TRAP when the trap feature is compiled in.
- IDLE moves to FETCH unconditionally after one cycle.
- FETCH:
  - imem_req = 1 and imem_addr = pc.
  - On imem_valid: latch instr <= imem_rdata and go to EXEC.
  - Otherwise stay in FETCH and hold the request.
- EXEC:
  - instr_valid = 1.
  - stall = 1: remain in EXEC; instr and pc are unchanged.
  - stall = 0: pc <= next_pc, then go to FETCH.
- next_pc priority, highest first:
  - jr: jr_addr.
  - jump: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - branch && zero: pc_plus4 + (sext_imm << 2).
  - Otherwise: pc_plus4.
- Arithmetic is modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000, and so do branch targets.
- Redirect inputs are sampled only in EXEC with stall = 0; they are ignored in every other state.
- imem_valid is ignored outside FETCH.

## Timing
- Reset values:
  - pc = RESET_PC, state = IDLE.
  - instr = 32'h0000_0000 (nop).
  - instr_valid = 0, imem_req = 0, misalign = 0.
- First request: imem_req rises in the 2nd cycle after rst_n deasserts.
- Fetch-to-execute latency: instr_valid rises on the cycle after the imem_valid edge.
- Minimum instruction period is 2 cycles (FETCH + EXEC) with zero-wait memory. Each wait cycle adds one.
- pc changes only on the EXEC→FETCH edge. pc_plus4 and imem_addr are combinational from pc.
- Reset mid-fetch or mid-EXEC: everything returns to reset values immediately. An in-flight imem_valid is discarded.
- Simultaneous jr, jump and taken branch: the priority above applies.
- stall asserted outside EXEC has no effect.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - If next_pc[1:0] != 0 on an EXEC→FETCH transition, pc is not updated and the FSM enters TRAP.
  - TRAP: misalign = 1, imem_req = 0, instr_valid = 0; exits only by reset.
- Not defined:
  - next_pc[1:0] is forced to 2'b00.
  - No TRAP state; misalign is tied to 0.

## Structure
- Shared package mips_fetch_pkg holds:
  - The state enum (IDLE, FETCH, EXEC, TRAP).
  - Default RESET_PC.
  - The PC_INCR = 32'd4 constant.
- Sub-module fetch_next_pc: purely combinational next-PC mux and adders. Inputs are pc_plus4, instr[25:0], sext_imm, jr_addr and the redirect flags; output is next_pc.

## Test plan
- Reset with RESET_PC = 32'h0000_0040 and zero-wait memory → imem_addr sequence 0x40, 0x44, 0x48; instr_valid toggles every other cycle.
- Taken branch at pc 0x100 with sext_imm = 32'hFFFF_FFFE, branch = zero = 1 → next imem_addr = 0x0FC. The same with zero = 0 → 0x104.
- jr = 1, jump = 1 and taken branch in the same EXEC cycle, jr_addr = 0x2000 → next imem_addr = 0x2000.
- stall held 3 cycles in EXEC, then imem_valid delayed 2 cycles → instr and pc stable throughout; instr_valid rises one cycle after imem_valid.
- pc = 32'hFFFF_FFFC sequential → next pc 32'h0000_0000.
- rst_n pulsed low while in FETCH with imem_valid high → instr stays 0 and pc = RESET_PC.
- With FETCH_MISALIGN_TRAP_EN defined, jr_addr = 0x1002 → misalign = 1 and imem_req = 0 until reset.
